// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_ctrl_if
// Purpose  : Miss-request, AXI AR/R and return-buffer signals of the refill
//            controller; master = controller side, slave = environment side.
// Revision : 1.0  initial release
// ============================================================================
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_uncache;
    logic              miss_ready;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arready;
    logic              rvalid;
    logic              rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rready;
    logic              beat_valid;
    logic              beat_last;
    logic [DATA_W-1:0] beat_data;
    logic [1:0]        offset;
    logic              uncache_pipe;
    logic              refill_done;
    logic              refill_err;
    logic              busy;

    modport master (
        input  miss_req, miss_addr, miss_uncache, arready,
               rvalid, rlast, rdata, rresp,
        output miss_ready, arvalid, araddr, arlen, arsize, arburst, rready,
               beat_valid, beat_last, beat_data, offset, uncache_pipe,
               refill_done, refill_err, busy
    );

    modport slave (
        output miss_req, miss_addr, miss_uncache, arready,
               rvalid, rlast, rdata, rresp,
        input  miss_ready, arvalid, araddr, arlen, arsize, arburst, rready,
               beat_valid, beat_last, beat_data, offset, uncache_pipe,
               refill_done, refill_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_ctrl
// Purpose  : ICache miss refill controller (AXI AR + R beats -> return buffer).
//            Optional macro RLAST_CHECK_EN: terminate on beat count, flag rlast
//            disagreement as an error.
// Revision : 1.0  initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    icache_refill_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [1:0]        r_offset;
    logic [1:0]        r_cnt;
    logic              r_uncache;
    logic              r_err;

    logic              w_accept;
    logic              w_beat;
    logic              w_exp_last;
    logic              w_last;
    logic              w_beat_err;
    logic              w_miss_ready;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_done;
    logic              w_unused_ok;

    assign w_accept   = (r_state == S_IDLE) & bus.miss_req;
    assign w_beat     = (r_state == S_R) & bus.rvalid;
    assign w_exp_last = (r_cnt == r_arlen[1:0]);

`ifdef RLAST_CHECK_EN
    // Length is owned by the counter; rlast only serves as a consistency check.
    assign w_last     = w_exp_last;
    assign w_beat_err = (bus.rresp != 2'b00) | (bus.rlast != w_exp_last);
`else
    assign w_last     = bus.rlast;
    assign w_beat_err = (bus.rresp != 2'b00);
`endif

    assign w_unused_ok = ^{bus.miss_addr[1:0], w_exp_last};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_miss_ready = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_miss_ready = rstn;
                if (bus.miss_req) w_next = S_AR;
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (bus.arready) w_next = S_R;
            end
            S_R: begin
                w_rready = 1'b1;
                if (w_beat && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_araddr  <= '0;
            r_arlen   <= 8'd0;
            r_offset  <= 2'd0;
            r_cnt     <= 2'd0;
            r_uncache <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                // Uncached fetches are 2-word aligned, lines are 4-word aligned.
                r_araddr  <= bus.miss_uncache ? {bus.miss_addr[ADDR_W-1:3], 3'b000}
                                              : {bus.miss_addr[ADDR_W-1:4], 4'b0000};
                r_arlen   <= bus.miss_uncache ? 8'd1 : 8'd3;
                r_offset  <= bus.miss_addr[3:2];
                r_uncache <= bus.miss_uncache;
                r_cnt     <= 2'd0;
                r_err     <= 1'b0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 2'd1;
                if (w_beat_err) r_err <= 1'b1;
            end
        end
    end

    assign bus.miss_ready   = w_miss_ready;
    assign bus.arvalid      = w_arvalid;
    assign bus.araddr       = r_araddr;
    assign bus.arlen        = r_arlen;
    assign bus.arsize       = 3'b010;
    assign bus.arburst      = 2'b01;
    assign bus.rready       = w_rready;
    assign bus.beat_valid   = w_beat;
    assign bus.beat_last    = w_beat & w_last;
    assign bus.beat_data    = w_beat ? bus.rdata : {DATA_W{1'b0}};
    assign bus.offset       = r_offset;
    assign bus.uncache_pipe = r_uncache;
    assign bus.refill_done  = w_done;
    assign bus.refill_err   = w_done & r_err;
    assign bus.busy         = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_ctrl
// Purpose  : Self-checking bench for icache_refill_ctrl (beat/done scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_refill_ctrl;
`ifdef RLAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   beat_cnt = 0;
    logic [32:0] exp_beats[$];
    logic        exp_err_q[$];

    icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Scoreboard: expected beats and completion status are queued by stimulus.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        ee;
        if (bus.beat_valid) begin
            beat_cnt++;
            total++;
            if (exp_beats.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got last=%0b data=%h, none expected", bus.beat_last, bus.beat_data);
            end else begin
                e = exp_beats.pop_front();
                if ({bus.beat_last, bus.beat_data} !== e) begin
                    bad++;
                    $display("FAIL beat: got last=%0b data=%h, want last=%0b data=%h", bus.beat_last, bus.beat_data, e[32], e[31:0]);
                end
            end
        end
        if (bus.refill_done) begin
            done_cnt++;
            total++;
            if (exp_err_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: refill_done with err=%0b", bus.refill_err);
            end else begin
                ee = exp_err_q.pop_front();
                if (bus.refill_err !== ee) begin
                    bad++;
                    $display("FAIL refill_err: got %0b want %0b", bus.refill_err, ee);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ar(input int d, output logic [31:0] addr, output logic [7:0] len, output logic stable);
        stable = bus.arvalid;
        addr   = bus.araddr;
        len    = bus.arlen;
        for (int i = 0; i < d; i++) begin
            bus.arready = 1'b0;
            step();
            if (!bus.arvalid || bus.araddr !== addr || bus.arlen !== len) stable = 1'b0;
        end
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
    endtask

    task automatic drive_r(input logic [1:0] rs[4], input logic lst[4], input logic el[4],
                           input int n, input int gapmax, output int acc);
        int g;
        logic [31:0] d;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            if (!bus.rready) break;
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                bus.rvalid = 1'b0;
                bus.rdata  = $urandom;
                bus.rlast  = 1'b1;
                bus.rresp  = 2'b11;
                step();
            end
            d = $urandom;
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rresp  = rs[k];
            bus.rlast  = lst[k];
            exp_beats.push_back({el[k], d});
            acc++;
            step();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    task automatic issue_miss(input logic [31:0] a, input logic unc);
        bus.miss_req     = 1'b1;
        bus.miss_addr    = a;
        bus.miss_uncache = unc;
        step();
        bus.miss_req     = 1'b0;
        bus.miss_addr    = 32'hDEAD_BEEF;
        bus.miss_uncache = ~unc;
    endtask

    // Full refill without checks; callers compare the returned observations.
    task automatic run_refill(input logic [31:0] a, input logic unc, input int ard, input int gapmax,
                              input logic [1:0] rs[4], input logic lst[4], input logic el[4],
                              input int n, input logic eerr,
                              output logic [31:0] ra, output logic [7:0] rl, output logic st, output int acc);
        exp_err_q.push_back(eerr);
        issue_miss(a, unc);
        drive_ar(ard, ra, rl, st);
        drive_r(rs, lst, el, n, gapmax, acc);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.miss_uncache = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        repeat (3) step();
        total++;
        if ({bus.miss_ready, bus.arvalid, bus.rready, bus.beat_valid, bus.beat_last, bus.refill_done,
             bus.refill_err, bus.busy, bus.uncache_pipe} !== 9'd0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000000", {bus.miss_ready, bus.arvalid, bus.rready,
                bus.beat_valid, bus.beat_last, bus.refill_done, bus.refill_err, bus.busy, bus.uncache_pipe});
        end
        total++;
        if ({bus.araddr, bus.arlen, bus.offset, bus.beat_data} !== 74'd0) begin
            bad++; $display("FAIL reset_regs: araddr=%h arlen=%h offset=%b data=%h want 0", bus.araddr, bus.arlen, bus.offset, bus.beat_data);
        end
        total++;
        if (bus.arsize !== 3'b010 || bus.arburst !== 2'b01) begin
            bad++; $display("FAIL reset_axi_const: arsize=%b arburst=%b want 010/01", bus.arsize, bus.arburst);
        end
        rstn = 1'b1;
        step();
        total++;
        if (bus.miss_ready !== 1'b1) begin
            bad++; $display("FAIL idle_ready: got %b want 1", bus.miss_ready);
        end
        bus.rvalid = 1'b1; bus.rlast = 1'b1;
        #1;
        total++;
        if (bus.rready !== 1'b0 || bus.beat_valid !== 1'b0) begin
            bad++; $display("FAIL idle_rvalid_ignored: rready=%b beat_valid=%b want 0/0", bus.rready, bus.beat_valid);
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        step();
    endtask

    task automatic test_cacheable();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc; int c0; int d0;
        for (int k = 0; k < 4; k++) begin rs[k] = 2'b00; lst[k] = (k == 3); el[k] = (k == 3); end
        c0 = cyc; d0 = done_cnt;
        run_refill(32'h1C00_0038, 1'b0, 0, 0, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (ra !== 32'h1C00_0030 || rl !== 8'd3) begin
            bad++; $display("FAIL cache_ar: araddr=%h arlen=%0d want 1c000030/3", ra, rl);
        end
        total++;
        if (st !== 1'b1) begin bad++; $display("FAIL cache_arvalid: stable=%b want 1", st); end
        total++;
        if (acc !== 4) begin bad++; $display("FAIL cache_beats: got %0d want 4", acc); end
        total++;
        if (bus.refill_done !== 1'b1 || (cyc - c0) !== 6) begin
            bad++; $display("FAIL cache_done_cycle: done=%b cycle=%0d want 1 at 7", bus.refill_done, cyc - c0 + 1);
        end
        total++;
        if (bus.offset !== 2'b10 || bus.uncache_pipe !== 1'b0 || bus.miss_ready !== 1'b0) begin
            bad++; $display("FAIL cache_latched: offset=%b unc=%b ready=%b want 10/0/0", bus.offset, bus.uncache_pipe, bus.miss_ready);
        end
        step();
        total++;
        if (bus.miss_ready !== 1'b1 || bus.busy !== 1'b0 || bus.offset !== 2'b10 || (done_cnt - d0) !== 1) begin
            bad++; $display("FAIL cache_after: ready=%b busy=%b offset=%b dones=%0d want 1/0/10/1",
                bus.miss_ready, bus.busy, bus.offset, done_cnt - d0);
        end
    endtask

    task automatic test_uncached();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc;
        for (int k = 0; k < 4; k++) begin rs[k] = 2'b00; lst[k] = (k == 1); el[k] = (k == 1); end
        run_refill(32'h1FE0_01E4, 1'b1, 1, 0, rs, lst, el, 2, 1'b0, ra, rl, st, acc);
        total++;
        if (ra !== 32'h1FE0_01E0 || rl !== 8'd1) begin
            bad++; $display("FAIL unc_ar: araddr=%h arlen=%0d want 1fe001e0/1", ra, rl);
        end
        total++;
        if (acc !== 2 || bus.refill_done !== 1'b1) begin
            bad++; $display("FAIL unc_beats: beats=%0d done=%b want 2/1", acc, bus.refill_done);
        end
        total++;
        if (bus.uncache_pipe !== 1'b1 || bus.offset !== 2'b01) begin
            bad++; $display("FAIL unc_latched: unc=%b offset=%b want 1/01", bus.uncache_pipe, bus.offset);
        end
        step();
    endtask

    task automatic test_stall();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc; int d0; int b0;
        for (int k = 0; k < 4; k++) begin rs[k] = 2'b00; lst[k] = (k == 3); el[k] = (k == 3); end
        d0 = done_cnt; b0 = beat_cnt;
        run_refill(32'h0000_1234, 1'b0, 5, 3, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (st !== 1'b1 || ra !== 32'h0000_1230 || rl !== 8'd3) begin
            bad++; $display("FAIL stall_ar: stable=%b araddr=%h arlen=%0d want 1/00001230/3", st, ra, rl);
        end
        step();
        step();
        total++;
        if ((done_cnt - d0) !== 1 || (beat_cnt - b0) !== 4 || acc !== 4) begin
            bad++; $display("FAIL stall_counts: dones=%0d beats=%0d driven=%0d want 1/4/4", done_cnt - d0, beat_cnt - b0, acc);
        end
    endtask

    task automatic test_error();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc;
        for (int k = 0; k < 4; k++) begin rs[k] = (k == 1) ? 2'b10 : 2'b00; lst[k] = (k == 3); el[k] = (k == 3); end
        run_refill(32'h2000_0100, 1'b0, 0, 1, rs, lst, el, 4, 1'b1, ra, rl, st, acc);
        total++;
        if (bus.refill_done !== 1'b1 || bus.refill_err !== 1'b1) begin
            bad++; $display("FAIL err_flag: done=%b err=%b want 1/1", bus.refill_done, bus.refill_err);
        end
        step();
        for (int k = 0; k < 4; k++) rs[k] = 2'b00;
        run_refill(32'h2000_0200, 1'b0, 0, 0, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (bus.refill_done !== 1'b1 || bus.refill_err !== 1'b0) begin
            bad++; $display("FAIL err_clear: done=%b err=%b want 1/0", bus.refill_done, bus.refill_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc; int d0;
        d0 = done_cnt;
        issue_miss(32'h0000_2008, 1'b0);
        drive_ar(0, ra, rl, st);
        bus.rvalid = 1'b1; bus.rdata = 32'h1111_0001; bus.rlast = 1'b0; bus.rresp = 2'b00;
        exp_beats.push_back({1'b0, 32'h1111_0001});
        step();
        bus.rdata = 32'h1111_0002;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({bus.arvalid, bus.rready, bus.beat_valid, bus.busy, bus.refill_done, bus.miss_ready} !== 6'd0 ||
            bus.offset !== 2'b00) begin
            bad++; $display("FAIL reset_mid: av=%b rr=%b bv=%b busy=%b done=%b ready=%b offset=%b want all 0",
                bus.arvalid, bus.rready, bus.beat_valid, bus.busy, bus.refill_done, bus.miss_ready, bus.offset);
        end
        bus.rvalid = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        total++;
        if ((done_cnt - d0) !== 0 || bus.miss_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_nodone: dones=%0d ready=%b want 0/1", done_cnt - d0, bus.miss_ready);
        end
        for (int k = 0; k < 4; k++) begin rs[k] = 2'b00; lst[k] = (k == 3); el[k] = (k == 3); end
        run_refill(32'h0000_2008, 1'b0, 0, 0, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (bus.refill_done !== 1'b1 || acc !== 4 || ra !== 32'h0000_2000) begin
            bad++; $display("FAIL reset_mid_recover: done=%b beats=%0d araddr=%h want 1/4/00002000", bus.refill_done, acc, ra);
        end
        step();
    endtask

    task automatic test_rlast_early();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc; int n_exp;
        for (int k = 0; k < 4; k++) begin
            rs[k]  = 2'b00;
            lst[k] = (k >= 2);
            el[k]  = CHK ? (k == 3) : lst[k];
        end
        n_exp = CHK ? 4 : 3;
        run_refill(32'h3000_0004, 1'b0, 0, 0, rs, lst, el, 4, CHK, ra, rl, st, acc);
        total++;
        if (acc !== n_exp || bus.refill_done !== 1'b1) begin
            bad++; $display("FAIL rlast_term: beats=%0d done=%b want %0d/1", acc, bus.refill_done, n_exp);
        end
        total++;
        if (bus.refill_err !== CHK) begin
            bad++; $display("FAIL rlast_err: got %b want %b", bus.refill_err, CHK);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] rs[4]; logic lst[4]; logic el[4];
        logic [31:0] ra; logic [7:0] rl; logic st; int acc;
        for (int k = 0; k < 4; k++) begin rs[k] = 2'b00; lst[k] = (k == 3); el[k] = (k == 3); end
        run_refill(32'h4000_0010, 1'b0, 0, 0, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (bus.refill_done !== 1'b1 || bus.miss_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_done: done=%b ready=%b want 1/0", bus.refill_done, bus.miss_ready);
        end
        step();
        total++;
        if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", bus.miss_ready); end
        run_refill(32'h4000_002C, 1'b0, 0, 0, rs, lst, el, 4, 1'b0, ra, rl, st, acc);
        total++;
        if (ra !== 32'h4000_0020 || bus.refill_done !== 1'b1 || bus.offset !== 2'b11) begin
            bad++; $display("FAIL b2b_second: araddr=%h done=%b offset=%b want 40000020/1/11", ra, bus.refill_done, bus.offset);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_cacheable();
        test_uncached();
        test_stall();
        test_error();
        test_reset_mid();
        test_rlast_early();
        test_back_to_back();
        repeat (2) step();
        total++;
        if (exp_beats.size() !== 0 || exp_err_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: beats_left=%0d dones_left=%0d want 0/0", exp_beats.size(), exp_err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
